// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment scanner with PWM
// brightness, per-digit blanking and tear-free (frame-synchronous) updates.
// Optional feature: define SEG7_LAMP_TEST_EN to add the lamp_test input.

// Per-digit storage lane: pending regs take every load, active regs take
// pending at the frame boundary (or the live inputs on a boundary load).
module seg7_digit_lane (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] nib_in,
  input  logic       dot_in,
  input  logic       blank_in,
  input  logic       load,
  input  logic       commit,
  output logic [3:0] nib_act,
  output logic       dot_act,
  output logic       blank_act
);
  logic [3:0] nib_pend;
  logic       dot_pend;
  logic       blank_pend;

  // Capture into pending on load; promote to active on frame commit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nib_pend   <= '0;
      dot_pend   <= 1'b0;
      blank_pend <= 1'b0;
      nib_act    <= '0;
      dot_act    <= 1'b0;
      blank_act  <= 1'b0;
    end else begin
      if (load) begin
        nib_pend   <= nib_in;
        dot_pend   <= dot_in;
        blank_pend <= blank_in;
      end
      if (commit) begin
        nib_act   <= load ? nib_in   : nib_pend;
        dot_act   <= load ? dot_in   : dot_pend;
        blank_act <= load ? blank_in : blank_pend;
      end
    end
  end
endmodule

module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SUB_DIV    = 1563,
  parameter int BRIGHT_W   = 4,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dots_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
`ifdef SEG7_LAMP_TEST_EN
  input  logic                  lamp_test,
`endif
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            segment,
  output logic                  dot,
  output logic                  frame_done
);
  localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SUB_W-1:0]    sub_cnt;
  logic [BRIGHT_W-1:0] sub_idx;
  logic [IDX_W-1:0]    idx;
  logic                sub_wrap, idx_wrap, frame_wrap;

  logic [DIGITS-1:0][3:0] nib_act;
  logic [DIGITS-1:0]      dot_act;
  logic [DIGITS-1:0]      blank_act;

  logic                lit;
  logic [DIGITS-1:0]   anode_d;
  logic [6:0]          seg_d;
  logic                dot_d;

  function automatic logic [6:0] hexdecode(input logic [3:0] n);
    case (n)
      4'h0: hexdecode = 7'h3F;  4'h1: hexdecode = 7'h06;
      4'h2: hexdecode = 7'h5B;  4'h3: hexdecode = 7'h4F;
      4'h4: hexdecode = 7'h66;  4'h5: hexdecode = 7'h6D;
      4'h6: hexdecode = 7'h7D;  4'h7: hexdecode = 7'h07;
      4'h8: hexdecode = 7'h7F;  4'h9: hexdecode = 7'h6F;
      4'hA: hexdecode = 7'h77;  4'hB: hexdecode = 7'h7C;
      4'hC: hexdecode = 7'h39;  4'hD: hexdecode = 7'h5E;
      4'hE: hexdecode = 7'h79;  default: hexdecode = 7'h71;
    endcase
  endfunction

  assign sub_wrap   = (sub_cnt == SUB_W'(SUB_DIV - 1));
  assign idx_wrap   = sub_wrap && (sub_idx == {BRIGHT_W{1'b1}});
  assign frame_wrap = idx_wrap && (idx == IDX_W'(DIGITS - 1));

  // Scan counters: sub-slot divider -> PWM sub-slot index -> digit index
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sub_cnt <= '0;
      sub_idx <= '0;
      idx     <= '0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap) sub_idx <= sub_idx + 1'b1;
      if (idx_wrap) idx <= frame_wrap ? '0 : idx + 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_lane
      seg7_digit_lane u_lane (
        .clock     (clock),
        .reset_n   (reset_n),
        .nib_in    (digits_in[4*g +: 4]),
        .dot_in    (dots_in[g]),
        .blank_in  (blank_in[g]),
        .load      (load),
        .commit    (frame_wrap),
        .nib_act   (nib_act[g]),
        .dot_act   (dot_act[g]),
        .blank_act (blank_act[g])
      );
    end
  endgenerate

  // Lit decision and active-high pin values for the digit being scanned;
  // sub-slot 0 is always dark so the anode switch never ghosts.
  always_comb begin
`ifdef SEG7_LAMP_TEST_EN
    if (lamp_test)
      lit = (sub_idx != '0);
    else
`endif
      lit = (sub_idx != '0) && (sub_idx <= brightness) && !blank_act[idx];
    anode_d = '0;
    seg_d   = '0;
    dot_d   = 1'b0;
    if (lit) begin
      anode_d = DIGITS'(1) << idx;
      seg_d   = hexdecode(nib_act[idx]);
      dot_d   = dot_act[idx];
`ifdef SEG7_LAMP_TEST_EN
      if (lamp_test) begin
        seg_d = 7'h7F;
        dot_d = 1'b1;
      end
`endif
    end
  end

  // Registered pins with polarity applied; reset drives them inactive at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anode      <= {DIGITS{ACTIVE_LOW}};
      segment    <= {7{ACTIVE_LOW}};
      dot        <= ACTIVE_LOW;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_d ^ {DIGITS{ACTIVE_LOW}};
      segment    <= seg_d ^ {7{ACTIVE_LOW}};
      dot        <= dot_d ^ ACTIVE_LOW;
      frame_done <= frame_wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded random test of seg7_scan_driver (4 digits, slot=8, frame=32).
// The driver pushes the expected pin state per cycle; a monitor pops and compares.
module tb_seg7_scan_driver;
  localparam int DIGITS  = 4;
  localparam int SUB_DIV = 2;
  localparam int BW      = 2;
  localparam int NSUB    = 1 << BW;
  localparam int SLOT    = SUB_DIV * NSUB;
  localparam int FRAME   = SLOT * DIGITS;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dots_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic [1:0]  brightness = '0;
  logic        lamp_test = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dot;
  logic        frame_done;

  seg7_scan_driver #(.DIGITS(DIGITS), .SUB_DIV(SUB_DIV), .BRIGHT_W(BW), .ACTIVE_LOW(1)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .digits_in  (digits_in),
    .dots_in    (dots_in),
    .blank_in   (blank_in),
    .load       (load),
    .brightness (brightness),
`ifdef SEG7_LAMP_TEST_EN
    .lamp_test  (lamp_test),
`endif
    .anode      (anode),
    .segment    (segment),
    .dot        (dot),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    int         tcyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: what is shown is a function of time since reset plus
  // the pending/active copies of the display contents.
  logic [15:0] p_dig, a_dig;
  logic [3:0]  p_dot, a_dot, p_blk, a_blk;
  int t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    p_dig = '0; a_dig = '0; p_dot = '0; a_dot = '0; p_blk = '0; a_blk = '0;
    t = 0;
  endtask

  // Called at a negedge with inputs already applied: predict the pins after
  // the coming posedge, update the model, advance to the next negedge.
  task automatic cycle();
    exp_t e;
    int pos, d, s;
    logic lit;
    logic [3:0] nib;
    pos = t % FRAME;
    d   = pos / SLOT;
    s   = (pos / SUB_DIV) % NSUB;
    if (lamp_test) lit = (s != 0);
    else           lit = (s != 0) && (s <= int'(brightness)) && !a_blk[d];
    nib    = a_dig[4*d +: 4];
    e.an   = lit ? ~(4'b0001 << d) : 4'hF;
    e.seg  = lit ? (lamp_test ? 7'h00 : ~hex_tab[nib]) : 7'h7F;
    e.dp   = lit ? (lamp_test ? 1'b0 : ~a_dot[d]) : 1'b1;
    e.fd   = ((t + 1) % FRAME == 0);
    e.tcyc = t + 1;
    q.push_back(e);
    if (load) begin p_dig = digits_in; p_dot = dots_in; p_blk = blank_in; end
    if ((t + 1) % FRAME == 0) begin a_dig = p_dig; a_dot = p_dot; a_blk = p_blk; end
    t++;
    @(negedge clock);
  endtask

  // Monitor: every clock after reset release presents one pin state
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (reset_n && q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("pins@t%0d", e.tcyc), {19'd0, anode, segment, dot, frame_done},
          {19'd0, e.an, e.seg, e.dp, e.fd});
    end
  end

  task automatic run_frames(input int nfr, input int bnd_every);
    for (int f = 0; f < nfr; f++) begin
      brightness = 2'($urandom_range(0, 3));
      blank_in   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
`ifdef SEG7_LAMP_TEST_EN
      lamp_test  = ($urandom_range(0, 4) == 0);
`endif
      for (int c = 0; c < FRAME; c++) begin
        digits_in = 16'($urandom);
        dots_in   = 4'($urandom);
        if (c == FRAME / 2 && $urandom_range(0, 3) == 0) brightness = 2'($urandom_range(0, 3));
        load = ($urandom_range(0, 11) == 0) ||
               ((f % bnd_every == 0) && ((t + 1) % FRAME == 0));
        cycle();
      end
    end
    load = 1'b0;
  endtask

  task automatic check_inactive(input string tag);
    chk({tag, "_anode"}, 32'(anode), 32'hF);
    chk({tag, "_segment"}, 32'(segment), 32'h7F);
    chk({tag, "_dot"}, 32'(dot), 32'h1);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    check_inactive("reset");
    reset_n = 1'b1;
    // Directed opener: 1234 with dot on digit 0 at full brightness
    digits_in = 16'h1234; dots_in = 4'b0001; brightness = 2'd3; load = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME - 1; i++) cycle();
    run_frames(40, 3);
    // Asynchronous reset in the middle of a slot
    #2 reset_n = 1'b0;
    q.delete();
    #1 check_inactive("async_reset");
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
    run_frames(30, 2);
    begin
      int guard = 0;
      while (q.size() > 0 && guard < 10) begin @(negedge clock); guard++; end
      if (q.size() > 0) chk("scoreboard_drain", 32'(q.size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
